// File: rtl/xor_parity_accum_if.sv
// Frame-in / result-out bus for xor_parity_accum.
// Both halves use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface xor_parity_accum_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int CW = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_xor;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_trunc;

    // Producer/consumer side (testbench or upstream logic).
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_xor, out_parity, out_count, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_xor, out_parity, out_count, out_trunc
    );
endinterface

// File: rtl/xor_parity_accum.sv
// XOR/parity accumulator over frames of up to MAX_LEN words, presenting one result per frame.
// Optional macro XOR_ODD_EN selects odd parity for out_parity (even parity when undefined).
module xor_parity_accum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xor_parity_accum_if.slave    bus,
    output logic [1:0]           dbg_state
);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_inc;
    logic             trunc;
    logic             accept;
    logic             handoff;
    logic             closing;
    logic             hold;
    logic             par_raw;

    assign hold      = (state == HOLD);
    assign accept    = bus.in_valid && !hold;
    assign handoff   = hold && bus.out_ready;
    // count stays below MAX_LEN outside HOLD, so the increment cannot overflow CW bits.
    assign count_inc = count + CW'(1);
    assign closing   = bus.in_last || (count_inc == CW'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = closing ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // acc is already 0 in IDLE, so the first word of a frame needs no special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            trunc <= 1'b0;
        end else if (handoff) begin
            acc   <= '0;
            count <= '0;
            trunc <= 1'b0;
        end else if (accept) begin
            acc   <= acc ^ bus.in_data;
            count <= count_inc;
            trunc <= (count_inc == CW'(MAX_LEN)) && !bus.in_last;
        end
    end

`ifdef XOR_ODD_EN
    assign par_raw = ~^acc;
`else
    assign par_raw = ^acc;
`endif

    // All result fields are forced to 0 outside HOLD so stale values never leak out.
    always_comb begin
        bus.in_ready   = !hold;
        bus.out_valid  = hold;
        bus.out_xor    = hold ? acc : '0;
        bus.out_parity = hold && par_raw;
        bus.out_count  = hold ? count : '0;
        bus.out_trunc  = hold && trunc;
        dbg_state      = state;
    end
endmodule

// File: tb/tb_xor_parity_accum.sv
// Directed self-checking bench for xor_parity_accum (WIDTH=8, MAX_LEN=4).
// Expected values are hand-computed constants; parity expectations follow XOR_ODD_EN.
module tb_xor_parity_accum;
  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;

`ifdef XOR_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  xor_parity_accum_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

  xor_parity_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic logic par(input logic even_par);
    return even_par ^ ODD;
  endfunction

  // scoreboard-style comparison helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] x,
                         input logic p, input logic [2:0] c, input logic t);
    chk({tag, ".valid"},  32'(bus.out_valid),  32'(v));
    chk({tag, ".xor"},    32'(bus.out_xor),    32'(x));
    chk({tag, ".parity"}, 32'(bus.out_parity), 32'(p));
    chk({tag, ".count"},  32'(bus.out_count),  32'(c));
    chk({tag, ".trunc"},  32'(bus.out_trunc),  32'(t));
  endtask

  // driver tasks: called and returning at a falling edge
  task automatic send(input logic [7:0] d, input logic l);
    logic rdy;
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int i = 0; i < 16 && !got; i++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      got = rdy;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("send.accept", 32'(got), 32'(1));
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("take.idle_valid", 32'(bus.out_valid), 32'(0));
    chk("take.idle_ready", 32'(bus.in_ready),  32'(1));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("rst", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // 3-word frame closed by in_last, then held with out_ready low
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h3C, 1'b1);
    chk_out("f1", 1'b1, 8'hC3, par(1'b0), 3'd3, 1'b0);
    chk("f1.in_ready", 32'(bus.in_ready), 32'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("f1.hold", 1'b1, 8'hC3, par(1'b0), 3'd3, 1'b0);
      chk("f1.hold_ready", 32'(bus.in_ready), 32'(0));
    end
    bus.in_valid = 1'b0;
    take();
    chk_out("f1.after", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // single-word frame
    send(8'h01, 1'b1);
    chk_out("f2", 1'b1, 8'h01, par(1'b1), 3'd1, 1'b0);
    take();

    // truncation at MAX_LEN; fifth word waits for handoff and opens a new frame
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h44, 1'b0);
    send(8'h88, 1'b0);
    chk_out("f3", 1'b1, 8'hFF, par(1'b0), 3'd4, 1'b1);
    chk("f3.in_ready", 32'(bus.in_ready), 32'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("f3.wait", 1'b1, 8'hFF, par(1'b0), 3'd4, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("f3.idle_valid", 32'(bus.out_valid), 32'(0));
    chk("f3.idle_ready", 32'(bus.in_ready),  32'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("f3.accum_valid", 32'(bus.out_valid), 32'(0));
    send(8'h00, 1'b1);
    chk_out("f4", 1'b1, 8'h55, par(1'b0), 3'd2, 1'b0);
    take();

    // in_last on exactly the MAX_LEN-th word is not a truncation
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b1);
    chk_out("f5", 1'b1, 8'h83, par(1'b1), 3'd4, 1'b0);
    take();

    // reset mid-frame discards the partial result
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("rst_mid", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("rst_mid.in_ready", 32'(bus.in_ready), 32'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("rst_mid.rel", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    send(8'hAA, 1'b1);
    chk_out("f6", 1'b1, 8'hAA, par(1'b0), 3'd1, 1'b0);
    take();

    // reset in HOLD drops the pending result immediately
    send(8'h5A, 1'b1);
    chk("f7.valid", 32'(bus.out_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    chk_out("rst_hold", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_data = 8'hEE;
    bus.in_last = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("rst_hold.idle", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    send(8'h03, 1'b1);
    chk_out("f8", 1'b1, 8'h03, par(1'b0), 3'd1, 1'b0);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
